// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_wb_arbiter_pkg                                           |
// | Shared widths, write-select codes and FIFO entry layout.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package regfile_wb_arbiter_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int Q_DEPTH  = 4;
    localparam int PCNT_W   = 3;

    localparam logic W_SEL_ALU   = 1'b0;
    localparam logic W_SEL_OTHER = 1'b1;

    // FIFO entry: {addr, data}
    localparam int ENT_W        = ADDR_W + DATA_W;
    localparam int ENT_DATA_LSB = 0;
    localparam int ENT_ADDR_LSB = DATA_W;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_ALU   = 2'd1,
        WB_OTHER = 2'd2
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_wb_arbiter_if                                            |
// | Write sources, scoreboard status and register-file write port.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic                alu_valid;
    logic [ADDR_W-1:0]   alu_addr;
    logic [DATA_W-1:0]   alu_data;
    logic                oth_valid;
    logic                oth_ready;
    logic [ADDR_W-1:0]   oth_addr;
    logic [DATA_W-1:0]   oth_data;
    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_addr;
    logic                issue_ready;
    logic [NUM_REGS-1:0] busy;
    logic [PCNT_W-1:0]   q_count;
    logic                waw_err;
    logic                w_enable;
    logic                w_select;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_alu;
    logic [DATA_W-1:0]   w_other;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output oth_valid, oth_addr, oth_data,
        output issue_valid, issue_addr,
        input  oth_ready, issue_ready, busy, q_count, waw_err,
        input  w_enable, w_select, w_addr, w_alu, w_other
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  oth_valid, oth_addr, oth_data,
        input  issue_valid, issue_addr,
        output oth_ready, issue_ready, busy, q_count, waw_err,
        output w_enable, w_select, w_addr, w_alu, w_other
    );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_fifo                                                          |
// | Synchronous power-of-two FIFO; push when full / pop when empty    |
// | are ignored. Revision: 1.0                                       |
// +------------------------------------------------------------------+
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   push_i,
    input  wire logic [WIDTH-1:0]       din_i,
    input  wire logic                   pop_i,
    output logic      [WIDTH-1:0]       dout_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic      [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_wb_arbiter                                               |
// | Merges ALU and queued long-latency results onto the regfile      |
// | write port and tracks pending writes per register. Rev: 1.0      |
// +------------------------------------------------------------------+
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           rst,
    regfile_wb_arbiter_if.slave bus
);

    logic                fifo_full, fifo_empty, push, pop, issue_fire;
    logic [ENT_W-1:0]    fifo_dout;
    logic [PCNT_W-1:0]   fifo_count;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;
    wb_src_e             src;
    logic [PCNT_W-1:0]   cnt_q [NUM_REGS];
    logic [PCNT_W-1:0]   cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                waw_err_q, w_enable_q, w_select_q;
    logic [ADDR_W-1:0]   w_addr_q;
    logic [DATA_W-1:0]   w_alu_q, w_other_q;

    wb_fifo #(
        .DEPTH (Q_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   ({bus.oth_addr, bus.oth_data}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_addr = fifo_dout[ENT_ADDR_LSB +: ADDR_W];
    assign head_data = fifo_dout[ENT_DATA_LSB +: DATA_W];
    assign push      = bus.oth_valid && !fifo_full;

    // ALU never stalls, so it always takes priority over the queue.
    always_comb begin
        src = WB_IDLE;
        if (bus.alu_valid)  src = WB_ALU;
        else if (!fifo_empty) src = WB_OTHER;
    end
    assign pop = (src == WB_OTHER);

    assign issue_fire = bus.issue_valid && bus.issue_ready;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (issue_fire && (bus.issue_addr == ADDR_W'(i)) &&
                !(pop && (head_addr == ADDR_W'(i)))) begin
                cnt_d[i] = cnt_q[i] + PCNT_W'(1);
            end else if (pop && (head_addr == ADDR_W'(i)) &&
                         !(issue_fire && (bus.issue_addr == ADDR_W'(i))) &&
                         (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - PCNT_W'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            assign busy[gi] = (cnt_q[gi] != '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
            waw_err_q  <= 1'b0;
            w_enable_q <= 1'b0;
            w_select_q <= W_SEL_ALU;
            w_addr_q   <= '0;
            w_alu_q    <= '0;
            w_other_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
            if (bus.alu_valid && busy[bus.alu_addr]) waw_err_q <= 1'b1;
            case (src)
                WB_ALU: begin
                    w_enable_q <= 1'b1;
                    w_select_q <= W_SEL_ALU;
                    w_addr_q   <= bus.alu_addr;
                    w_alu_q    <= bus.alu_data;
                end
                WB_OTHER: begin
                    w_enable_q <= 1'b1;
                    w_select_q <= W_SEL_OTHER;
                    w_addr_q   <= head_addr;
                    w_other_q  <= head_data;
                end
                default: w_enable_q <= 1'b0;
            endcase
        end
    end

    assign bus.oth_ready   = !fifo_full;
    assign bus.issue_ready = (cnt_q[bus.issue_addr] < PCNT_W'(Q_DEPTH));
    assign bus.busy        = busy;
    assign bus.q_count     = fifo_count;
    assign bus.waw_err     = waw_err_q;
    assign bus.w_enable    = w_enable_q;
    assign bus.w_select    = w_select_q;
    assign bus.w_addr      = w_addr_q;
    assign bus.w_alu       = w_alu_q;
    assign bus.w_other     = w_other_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_regfile_wb_arbiter                                            |
// | Directed + random stimulus against a queue-based reference       |
// | model; write-port scoreboard checked by an independent monitor.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    typedef struct {
        bit          en;
        bit          sel;
        logic [2:0]  addr;
        logic [31:0] alu;
        logic [31:0] oth;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    regfile_wb_arbiter_if bus();

    regfile_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    exp_t        sb[$];
    logic [2:0]  mqa[$];
    logic [31:0] mqd[$];
    int          m_cnt[8];
    bit          m_waw = 0;
    exp_t        m_out = '{0, 0, 3'd0, 32'd0, 32'd0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [7:0] model_busy();
        logic [7:0] b = '0;
        for (int k = 0; k < 8; k++) b[k] = (m_cnt[k] != 0);
        return b;
    endfunction

    task automatic step(input bit r, input bit av, input logic [2:0] aa, input logic [31:0] ad,
                        input bit ov, input logic [2:0] oa, input logic [31:0] od,
                        input bit iv, input logic [2:0] ia);
        bit ready, iready;
        @(negedge clk);
        rst             = r;
        bus.alu_valid   = av;
        bus.alu_addr    = aa;
        bus.alu_data    = ad;
        bus.oth_valid   = ov;
        bus.oth_addr    = oa;
        bus.oth_data    = od;
        bus.issue_valid = iv;
        bus.issue_addr  = ia;
        #1;
        ready  = (mqa.size() < 4);
        iready = (m_cnt[ia] < 4);
        chk("oth_ready",   32'(bus.oth_ready),   32'(ready));
        chk("q_count",     32'(bus.q_count),     32'(mqa.size()));
        chk("busy",        32'(bus.busy),        32'(model_busy()));
        chk("issue_ready", 32'(bus.issue_ready), 32'(iready));
        chk("waw_err",     32'(bus.waw_err),     32'(m_waw));
        if (r) begin
            mqa.delete();
            mqd.delete();
            for (int k = 0; k < 8; k++) m_cnt[k] = 0;
            m_waw = 0;
            m_out = '{0, 0, 3'd0, 32'd0, 32'd0};
        end else begin
            if (av) begin
                if (m_cnt[aa] != 0) m_waw = 1;
                m_out.en = 1; m_out.sel = 0; m_out.addr = aa; m_out.alu = ad;
            end else if (mqa.size() > 0) begin
                logic [2:0]  ha = mqa.pop_front();
                logic [31:0] hd = mqd.pop_front();
                if (m_cnt[ha] > 0) m_cnt[ha]--;
                m_out.en = 1; m_out.sel = 1; m_out.addr = ha; m_out.oth = hd;
            end else begin
                m_out.en = 0;
            end
            if (ov && ready) begin
                mqa.push_back(oa);
                mqd.push_back(od);
            end
            if (iv && iready) m_cnt[ia]++;
        end
        sb.push_back(m_out);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 3'd0, 32'd0, 0, 3'd0, 32'd0, 0, 3'd0);
    endtask

    // Monitor: one expected write-port state per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.w_enable !== e.en || bus.w_select !== e.sel || bus.w_addr !== e.addr ||
                    bus.w_alu !== e.alu || bus.w_other !== e.oth) begin
                    errors++;
                    $display("FAIL wport: got en=%b sel=%b addr=%0d alu=%h oth=%h expected en=%b sel=%b addr=%0d alu=%h oth=%h at %0t",
                             bus.w_enable, bus.w_select, bus.w_addr, bus.w_alu, bus.w_other,
                             e.en, e.sel, e.addr, e.alu, e.oth, $time);
                end
            end
        end
    end

    initial begin
        bus.alu_valid = 0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.oth_valid = 0; bus.oth_addr = '0; bus.oth_data = '0;
        bus.issue_valid = 0; bus.issue_addr = '0;
        for (int k = 0; k < 8; k++) m_cnt[k] = 0;

        step(1, 0, 3'd0, 32'd0, 0, 3'd0, 32'd0, 0, 3'd0);
        step(1, 0, 3'd0, 32'd0, 0, 3'd0, 32'd0, 0, 3'd0);

        // Single ALU write
        step(0, 1, 3'd3, 32'hDEADBEEF, 0, 3'd0, 32'd0, 0, 3'd0);
        idle(2);

        // Issue then other-path write to r5
        step(0, 0, 3'd0, 32'd0, 0, 3'd0, 32'd0, 1, 3'd5);
        step(0, 0, 3'd0, 32'd0, 1, 3'd5, 32'h12345678, 0, 3'd0);
        idle(3);

        // Fill the queue under a continuous ALU stream, then drain
        for (int a = 1; a <= 4; a++) step(0, 0, 3'd0, 32'd0, 0, 3'd0, 32'd0, 1, 3'(a));
        for (int a = 1; a <= 4; a++) step(0, 1, 3'd0, 32'hA000 + a, 1, 3'(a), 32'hB000 + a, 0, 3'd0);
        step(0, 1, 3'd0, 32'hA005, 1, 3'd1, 32'hB005, 0, 3'd0);
        step(0, 1, 3'd0, 32'hA006, 0, 3'd0, 32'd0, 0, 3'd0);
        idle(5);

        // ALU and non-empty queue in the same cycle
        step(0, 0, 3'd0, 32'd0, 0, 3'd0, 32'd0, 1, 3'd7);
        step(0, 0, 3'd0, 32'd0, 1, 3'd7, 32'hC0DE0007, 0, 3'd0);
        step(0, 1, 3'd6, 32'h66666666, 0, 3'd0, 32'd0, 0, 3'd0);
        idle(2);

        // Saturate r2's pending counter, then a WAW from the ALU
        for (int k = 0; k < 5; k++) step(0, 0, 3'd0, 32'd0, 0, 3'd0, 32'd0, 1, 3'd2);
        step(0, 1, 3'd2, 32'h22222222, 0, 3'd0, 32'd0, 0, 3'd0);
        idle(1);
        for (int k = 0; k < 4; k++) step(0, 0, 3'd0, 32'd0, 1, 3'd2, 32'hD0 + k, 0, 3'd0);
        idle(4);

        // Reset with three queued entries
        for (int k = 0; k < 3; k++) step(0, 0, 3'd0, 32'd0, 0, 3'd0, 32'd0, 1, 3'd1);
        for (int k = 0; k < 3; k++) step(0, 1, 3'd0, 32'hE0 + k, 1, 3'd1, 32'hF0 + k, 0, 3'd0);
        step(1, 1, 3'd0, 32'hE9, 0, 3'd0, 32'd0, 0, 3'd0);
        idle(4);

        // Randomized legal traffic
        for (int i = 0; i < 600; i++) begin
            bit         r, av, ov, iv;
            logic [2:0] aa, oa, ia;
            int         nq;
            r  = ($urandom % 80) == 0;
            av = (((i / 40) % 5) == 4) ? 1'b1 : (($urandom % 10) < 4);
            aa = 3'($urandom);
            oa = 3'($urandom);
            ia = 3'($urandom);
            nq = 0;
            foreach (mqa[k]) if (mqa[k] == oa) nq++;
            ov = (($urandom % 10) < 6) && (m_cnt[oa] > nq);
            iv = ($urandom % 10) < 4;
            step(r, av, aa, $urandom, ov, oa, $urandom, iv, ia);
        end

        idle(2);
        @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
